// File: rtl/dw_stream_fifo.sv
// rtl/dw_stream_fifo.sv - valid/ready stream FIFO with fill level, almost-full and synchronous flush
// Pointers carry an extra wrap bit so full and empty are distinguishable without a separate counter.
module dw_stream_fifo #(
   parameter int DW        = 8,
   parameter int DEPTH     = 4,
   parameter int AFULL_THR = DEPTH - 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [DW-1:0]              din_i,
   input  logic                       vld_i,
   output logic                       rdy_o,
   output logic [DW-1:0]              dout_o,
   output logic                       vld_o,
   input  logic                       rdy_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       afull_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] THR     = AFULL_THR[AW:0];

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Ready never depends on rdy_i: a push into a full FIFO waits even if a pop happens alongside.
   assign rdy_o = !full && !flush_i && !rst_i;
   assign vld_o = !empty;
   assign push  = vld_i && rdy_o;
   assign pop   = vld_o && rdy_i;

   assign dout_o = vld_o ? mem[rd_ptr[AW-1:0]] : '0;

   assign count   = wr_ptr - rd_ptr;
   assign count_o = count;
   assign afull_o = (count >= THR);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; push is already blocked during reset and flush.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din_i;
   end

endmodule

// File: tb/tb_dw_stream_fifo.sv
// tb/tb_dw_stream_fifo.sv - self-checking bench for dw_stream_fifo against a queue reference model
module tb_dw_stream_fifo;
   localparam int DW        = 8;
   localparam int DEPTH     = 4;
   localparam int AFULL_THR = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [DW-1:0] din;
   logic          vld_in;
   logic          rdy_out;
   logic [DW-1:0] dout;
   logic          vld_out;
   logic          rdy_in;
   logic [2:0]    count;
   logic          afull;

   dw_stream_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL_THR(AFULL_THR)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .din_i   (din),
      .vld_i   (vld_in),
      .rdy_o   (rdy_out),
      .dout_o  (dout),
      .vld_o   (vld_out),
      .rdy_i   (rdy_in),
      .count_o (count),
      .afull_o (afull)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] sent_q[$];
   bit            model_valid = 1'b0;
   bit            last_push;
   string         phase;

   task automatic check_eq(input string tag, input int got_v, input int exp_v);
      n_checks++;
      if (got_v == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
   endtask

   // One clock: drive, check every output against the queue model mid-cycle, then advance the model.
   task automatic cycle(input bit r, input bit f, input bit v, input logic [DW-1:0] d, input bit rd);
      bit exp_rdy;
      bit exp_vld;
      bit do_pop;
      rst = r; flush = f; vld_in = v; din = d; rdy_in = rd;
      @(negedge clk);
      exp_rdy = !r && !f && (model_q.size() < DEPTH);
      exp_vld = (model_q.size() > 0);
      if (model_valid) begin
         check_eq({phase, ".rdy"},   int'(rdy_out), int'(exp_rdy));
         check_eq({phase, ".vld"},   int'(vld_out), int'(exp_vld));
         check_eq({phase, ".dout"},  int'(dout),    exp_vld ? int'(model_q[0]) : 0);
         check_eq({phase, ".count"}, int'(count),   model_q.size());
         check_eq({phase, ".afull"}, int'(afull),   int'(model_q.size() >= AFULL_THR));
         if (vld_out && rd) got_q.push_back(dout);
      end
      last_push = model_valid && v && exp_rdy;
      do_pop    = model_valid && exp_vld && rd;
      if (last_push) sent_q.push_back(d);
      @(posedge clk);
      if (r) begin
         model_q.delete();
         model_valid = 1'b1;
      end else if (f) begin
         model_q.delete();
      end else begin
         if (do_pop)    void'(model_q.pop_front());
         if (last_push) model_q.push_back(d);
      end
      #1;
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while (model_q.size() > 0 && guard < 50) begin
         cycle(0, 0, 0, 8'h00, 1);
         guard++;
      end
      check_eq({tag, ".drained"}, model_q.size(), 0);
   endtask

   initial begin
      logic [DW-1:0] d;
      int            exp_fill[5] = '{1, 2, 3, 4, 5};
      int            guard;
      int            pushes;

      rst = 1'b1; flush = 1'b0; vld_in = 1'b0; din = '0; rdy_in = 1'b0;

      phase = "reset";
      cycle(1, 0, 0, 8'h00, 0);
      cycle(1, 0, 0, 8'h00, 0);
      phase = "single";
      cycle(0, 0, 1, 8'hA5, 0);
      cycle(0, 0, 0, 8'h00, 0);
      cycle(0, 0, 0, 8'h00, 1);
      cycle(0, 0, 0, 8'h00, 0);
      check_eq("single.popped", got_q.size() > 0 ? int'(got_q[0]) : -1, 8'hA5);

      phase = "fill";
      got_q.delete();
      d = 8'h01;
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 1, d, 0);
         if (last_push) d++;
      end
      check_eq("fill.held_word", int'(d), 5);
      guard = 0;
      while ((d <= 8'h05 || model_q.size() > 0) && guard < 30) begin
         cycle(0, 0, d <= 8'h05, d, 1);
         if (last_push) d++;
         guard++;
      end
      check_eq("fill.drain_len", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++)
         check_eq($sformatf("fill.order%0d", i), int'(got_q[i]), exp_fill[i]);

      phase = "stream";
      cycle(0, 0, 1, 8'h80, 0);
      got_q.delete();
      for (int i = 0; i < 20; i++) cycle(0, 0, 1, DW'(i), 1);
      check_eq("stream.len", got_q.size(), 20);
      for (int i = 0; i < 20 && i < got_q.size(); i++)
         check_eq($sformatf("stream.word%0d", i), int'(got_q[i]), (i == 0) ? 8'h80 : i - 1);
      drain("stream");

      phase = "afull";
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, DW'(8'h30 + i), 0);
      cycle(0, 0, 0, 8'h00, 1);
      cycle(0, 0, 0, 8'h00, 0);
      check_eq("afull.at2", int'(afull), 0);

      phase = "flush";
      cycle(0, 0, 1, 8'h40, 0);
      check_eq("flush.stored", model_q.size(), 3);
      cycle(0, 1, 1, 8'h77, 1);
      cycle(0, 0, 0, 8'h00, 0);
      check_eq("flush.rdy_after", int'(rdy_out), 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, DW'(8'h50 + i), 0);
      phase = "midreset";
      cycle(1, 0, 1, 8'h99, 0);
      cycle(0, 0, 0, 8'h00, 0);
      check_eq("midreset.count_after", int'(count), 0);
      cycle(0, 0, 1, 8'h5A, 0);
      cycle(0, 0, 0, 8'h00, 1);
      drain("postreset");

      phase = "random";
      got_q.delete();
      sent_q.delete();
      pushes = 0;
      guard  = 0;
      while (pushes < 1000 && guard < 20000) begin
         cycle(0, 0, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
         if (last_push) pushes++;
         guard++;
      end
      check_eq("random.budget", int'(pushes == 1000), 1);
      drain("random");
      check_eq("random.count", got_q.size(), sent_q.size());
      for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
         if (got_q[i] != sent_q[i]) check_eq($sformatf("random.word%0d", i), int'(got_q[i]), int'(sent_q[i]));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
